mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the SLC-3 on-chip BRAM. It sits between the main memory and two requesters: the CPU control/datapath (port c) and the program loader / debug port (port l). It serialises their accesses, drives the BRAM enable, write-enable, address and data, and hides the BRAM's read latency (synchronous array plus output register) behind a request/done handshake. Arbitration is round-robin.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer between the CPU (port c) and the loader (port l) for a
// BRAM with a two-cycle read latency. Each access is a request/done handshake.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_done,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_done,
  output logic              busy,
  output logic              gnt_l,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [2:0] {IDLE, RD1, RD2, RD3, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_l_q, last_l_d;
  logic              gnt_l_q, gnt_l_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] l_rdata_q, l_rdata_d;
  logic              pick_l;
  logic              sel_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_l_q  <= 1'b1;
      gnt_l_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_l_q  <= last_l_d;
      gnt_l_q   <= gnt_l_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_l_d  = last_l_q;
    gnt_l_d   = gnt_l_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;
    // On a tie the loader wins only if the CPU was granted last.
    pick_l    = l_req && (!c_req || !last_l_q);
    sel_we    = pick_l ? l_we : c_we;
    unique case (state_q)
      IDLE: begin
        if (c_req || l_req) begin
          gnt_l_d = pick_l;
          addr_d  = pick_l ? l_addr  : c_addr;
          wdata_d = pick_l ? l_wdata : c_wdata;
          state_d = sel_we ? WR : RD1;
        end
      end
      RD1: state_d = RD2;
      RD2: state_d = RD3;
      RD3: begin
        if (gnt_l_q) l_rdata_d = mem_dout;
        else         c_rdata_d = mem_dout;
        state_d = DONE;
      end
      WR:  state_d = DONE;
      DONE: begin
        last_l_d = gnt_l_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign gnt_l    = gnt_l_q;
  assign mem_ena  = (state_q == RD1) || (state_q == RD2) || (state_q == RD3) || (state_q == WR);
  assign mem_wea  = (state_q == WR);
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;
  assign c_done   = (state_q == DONE) && !gnt_l_q;
  assign l_done   = (state_q == DONE) &&  gnt_l_q;
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: BRAM model with two-cycle read latency, table-driven accesses,
// and a scoreboard of expected completions popped on each done pulse.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [15:0] c_addr, c_wdata, c_rdata, l_addr, l_wdata, l_rdata;
  logic        c_done, l_done, busy, gnt_l, mem_ena, mem_wea;
  logic [15:0] mem_addr, mem_din, mem_dout;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_done(c_done),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_done(l_done),
    .busy(busy), .gnt_l(gnt_l), .mem_ena(mem_ena), .mem_wea(mem_wea),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // BRAM: synchronous array read followed by an output register.
  logic [15:0] bram [0:65535];
  logic [15:0] ram_q, dout_q;
  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  always @(posedge clk) begin
    if (pre_we) bram[pre_addr] <= pre_data;
    else if (mem_ena) begin
      if (mem_wea) bram[mem_addr] <= mem_din;
      else         ram_q <= bram[mem_addr];
    end
    dout_q <= ram_q;
  end
  assign mem_dout = dout_q;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          done_cyc;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ena_cnt = 0;
  int          wea_cnt = 0;
  logic [15:0] exp_c_rd = '0;
  logic [15:0] exp_l_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_acc(input bit port, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic [15:0] rdata, input int off);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.done_cyc = cyc + off;
    q.push_back(e);
  endtask

  // Present a request, hold it until done, release on the edge that ends the done cycle.
  task automatic drive(input bit port, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
    bit seen = 1'b0;
    if (port) begin l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata; end
    else      begin c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata; end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = port ? l_done : c_done;
    end
    if (!seen) chk(port ? "l_done_timeout" : "c_done_timeout", 32'(seen), 32'd1);
    @(posedge clk); #1;
    if (port) l_req = 1'b0; else c_req = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    reset = 1'b1; c_req = 1'b0; l_req = 1'b0;
    repeat (2) @(posedge clk);
    if (check) begin
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gnt_l", 32'(gnt_l), 32'd0);
      chk("rst_c_done", 32'(c_done), 32'd0);
      chk("rst_l_done", 32'(l_done), 32'd0);
      chk("rst_mem_ena", 32'(mem_ena), 32'd0);
      chk("rst_mem_wea", 32'(mem_wea), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      chk("rst_c_rdata", 32'(c_rdata), 32'd0);
      chk("rst_l_rdata", 32'(l_rdata), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    exp_c_rd = '0;
    exp_l_rd = '0;
  endtask

  // Scoreboard monitor: the queue front is always the access in progress.
  always @(negedge clk) begin
    if (reset) begin
      ena_cnt = 0;
      wea_cnt = 0;
    end else begin
      if (c_done && l_done) chk("done_overlap", 32'd1, 32'd0);
      if (busy) begin
        if (q.size() == 0) chk("unexpected_busy", 32'(busy), 32'd0);
        else begin
          chk("gnt_l", 32'(gnt_l), 32'(q[0].port));
          if (mem_ena) chk("mem_addr", 32'(mem_addr), 32'(q[0].addr));
          if (mem_wea) chk("mem_din", 32'(mem_din), 32'(q[0].wdata));
        end
      end
      if (mem_ena) ena_cnt++;
      if (mem_wea) wea_cnt++;
      if (c_done || l_done) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_port", 32'(l_done), 32'(e.port));
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("ena_cycles", 32'(ena_cnt), e.we ? 32'd1 : 32'd3);
          chk("wea_cycles", 32'(wea_cnt), e.we ? 32'd1 : 32'd0);
          if (!e.we) begin
            if (e.port) exp_l_rd = e.rdata;
            else        exp_c_rd = e.rdata;
          end
          chk("c_rdata", 32'(c_rdata), 32'(exp_c_rd));
          chk("l_rdata", 32'(l_rdata), 32'(exp_l_rd));
        end
        ena_cnt = 0;
        wea_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   t0;
    tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[1] = '{1'b1, 1'b1, 16'h3000, 16'h1234, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234};
    tbl[3] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[4] = '{1'b0, 1'b1, 16'h0020, 16'hA5A5, 16'h0000};
    tbl[5] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hA5A5};
    tbl[6] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};
    tbl[8] = '{1'b1, 1'b1, 16'h0000, 16'hFFFF, 16'h0000};
    tbl[9] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};

    reset = 1'b1;
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    pre_we = 1'b1; pre_addr = 16'h0010; pre_data = 16'hBEEF;
    @(posedge clk); #1;
    pre_we = 1'b0;
    do_reset(1'b1);

    // Back-to-back single-port accesses: read 4 cycles, write 2 cycles after the IDLE.
    foreach (tbl[i]) begin
      expect_acc(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata,
                 tbl[i].we ? 2 : 4);
      drive(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata);
    end

    // Simultaneous requests after reset: CPU first, then strict alternation.
    do_reset(1'b0);
    t0 = cyc;
    expect_acc(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
    expect_acc(1'b1, 1'b0, 16'h0020, 16'h0000, 16'hA5A5, 9);
    expect_acc(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 14);
    expect_acc(1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 19);
    fork
      begin
        drive(1'b0, 1'b0, 16'h0010, 16'h0000);
        drive(1'b0, 1'b0, 16'h3000, 16'h0000);
      end
      begin
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
      end
    join
    chk("alternation_len", 32'(cyc - t0), 32'd20);

    // Loader request raised during RD2 of a CPU read is served right after c_done.
    expect_acc(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
    expect_acc(1'b1, 1'b0, 16'h3000, 16'h0000, 16'h1234, 9);
    fork
      drive(1'b0, 1'b0, 16'h0010, 16'h0000);
      begin
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 16'h3000, 16'h0000);
      end
    join

    // CPU address changes during RD1; the latched address must be used.
    expect_acc(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
    fork
      drive(1'b0, 1'b0, 16'h0010, 16'h0000);
      begin
        @(posedge clk); #1;
        c_addr = 16'h0020;
      end
    join

    // Reset during RD2 aborts the read without a done.
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h3000;
    expect_acc(1'b0, 1'b0, 16'h3000, 16'h0000, 16'h1234, 4);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; c_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    exp_c_rd = '0;
    exp_l_rd = '0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_ena", 32'(mem_ena), 32'd0);
    chk("abort_c_done", 32'(c_done), 32'd0);
    chk("abort_c_rdata", 32'(c_rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    expect_acc(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 4);
    drive(1'b0, 1'b0, 16'h0010, 16'h0000);

    repeat (4) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
